// File: rtl/riscv_pipe_pkg.sv
// Shared RV32 pipeline definitions: datapath widths, MEM-stage FSM states and the
// MEM/WB bubble control word.
package riscv_pipe_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_t;

  typedef struct packed {
    logic memtoreg;
    logic regwrite;
  } wb_ctrl_t;

  // A bubble only needs its write-back controls cleared; data fields are held.
  localparam wb_ctrl_t WB_BUBBLE = '{memtoreg: 1'b0, regwrite: 1'b0};

endpackage

// File: rtl/memwb_reg.sv
// MEM/WB pipeline register with asynchronous active-high reset and a bubble input
// that clears the write-back controls while holding the data fields.
module memwb_reg #(
  parameter int unsigned XLEN   = riscv_pipe_pkg::XLEN,
  parameter int unsigned REG_AW = riscv_pipe_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bubble,
  input  logic [XLEN-1:0]   alu_result_in,
  input  logic [XLEN-1:0]   rdata_in,
  input  logic [REG_AW-1:0] rd_in,
  input  logic              memtoreg_in,
  input  logic              regwrite_in,
  output logic [XLEN-1:0]   readdata_out,
  output logic [XLEN-1:0]   alu_result_out,
  output logic [REG_AW-1:0] rd_out,
  output logic              memtoreg_out,
  output logic              regwrite_out
);
  import riscv_pipe_pkg::*;

  logic [XLEN-1:0]   readdata_d, readdata_q;
  logic [XLEN-1:0]   alu_result_d, alu_result_q;
  logic [REG_AW-1:0] rd_d, rd_q;
  wb_ctrl_t          ctrl_d, ctrl_q;

  always_comb begin
    readdata_d   = readdata_q;
    alu_result_d = alu_result_q;
    rd_d         = rd_q;
    ctrl_d       = WB_BUBBLE;
    if (!bubble) begin
      alu_result_d = alu_result_in;
      rd_d         = rd_in;
      ctrl_d       = '{memtoreg: memtoreg_in, regwrite: regwrite_in};
      if (memtoreg_in) readdata_d = rdata_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata_q   <= '0;
      alu_result_q <= '0;
      rd_q         <= '0;
      ctrl_q       <= '0;
    end else begin
      readdata_q   <= readdata_d;
      alu_result_q <= alu_result_d;
      rd_q         <= rd_d;
      ctrl_q       <= ctrl_d;
    end
  end

  assign readdata_out   = readdata_q;
  assign alu_result_out = alu_result_q;
  assign rd_out         = rd_q;
  assign memtoreg_out   = ctrl_q.memtoreg;
  assign regwrite_out   = ctrl_q.regwrite;

endmodule

// File: rtl/mem_stage.sv
// RV32 MEM stage: branch resolution, req/ack data-memory access with pipeline stall,
// and the MEM/WB register. Define MEM_STAGE_TIMEOUT_EN to abort accesses stuck in BUSY.
module mem_stage #(
  parameter int unsigned XLEN           = riscv_pipe_pkg::XLEN,
  parameter int unsigned REG_AW         = riscv_pipe_pkg::REG_AW
`ifdef MEM_STAGE_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 64
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [XLEN-1:0]   adder_in,
  input  logic              zero_in,
  input  logic [XLEN-1:0]   alu_result_in,
  input  logic [XLEN-1:0]   writedata_in,
  input  logic [REG_AW-1:0] rd_in,
  input  logic              branch_in,
  input  logic              memtoreg_in,
  input  logic              memwrite_in,
  input  logic              regwrite_in,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [XLEN-1:0]   dmem_addr,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic [XLEN-1:0]   dmem_rdata,
  input  logic              dmem_ack,
  output logic              stall,
  output logic              pcsrc,
  output logic [XLEN-1:0]   branch_target,
  output logic              flush,
  output logic [XLEN-1:0]   readdata_out,
  output logic [XLEN-1:0]   alu_result_out,
  output logic [REG_AW-1:0] rd_out,
  output logic              memtoreg_out,
  output logic              regwrite_out
`ifdef MEM_STAGE_TIMEOUT_EN
  ,
  output logic              dmem_err
`endif
);
  import riscv_pipe_pkg::*;

  logic       access;
  logic       wait_mem;
  logic       timeout;
  mem_state_t state_d, state_q;

  assign access     = memtoreg_in | memwrite_in;
  assign wait_mem   = access & ~dmem_ack;
  assign dmem_req   = access;
  assign dmem_we    = memwrite_in;
  assign dmem_addr  = alu_result_in;
  assign dmem_wdata = writedata_in;

  assign pcsrc         = branch_in & zero_in;
  assign branch_target = adder_in;
  assign flush         = pcsrc;

  // A timeout releases the pipeline but still bubbles MEM/WB.
  assign stall = wait_mem & ~timeout;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (wait_mem) state_d = BUSY;
      BUSY:    if (!access || dmem_ack || timeout) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

`ifdef MEM_STAGE_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES);

  logic [CntW-1:0] cnt_d, cnt_q;
  logic            err_d, err_q;

  // Ack in the same cycle wins over the timeout.
  assign timeout = (state_q == BUSY) & wait_mem & (cnt_q == CntMax);

  always_comb begin
    cnt_d = '0;
    if (state_q == BUSY && state_d == BUSY) cnt_d = cnt_q + 1'b1;
    err_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  // err_q stays 0 so reset clears the pulse; the pulse itself marks the timeout cycle.
  assign dmem_err = timeout | err_q;
`else
  assign timeout = 1'b0;
`endif

  memwb_reg #(
    .XLEN  (XLEN),
    .REG_AW(REG_AW)
  ) u_memwb_reg (
    .clk           (clk),
    .reset         (reset),
    .bubble        (wait_mem),
    .alu_result_in (alu_result_in),
    .rdata_in      (dmem_rdata),
    .rd_in         (rd_in),
    .memtoreg_in   (memtoreg_in),
    .regwrite_in   (regwrite_in),
    .readdata_out  (readdata_out),
    .alu_result_out(alu_result_out),
    .rd_out        (rd_out),
    .memtoreg_out  (memtoreg_out),
    .regwrite_out  (regwrite_out)
  );

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage; covers the timeout path when
// MEM_STAGE_TIMEOUT_EN is defined.
module tb_mem_stage;
  import riscv_pipe_pkg::*;

  logic        clk;
  logic        reset;
  logic [31:0] adder_in, alu_result_in, writedata_in, dmem_rdata;
  logic        zero_in, branch_in, memtoreg_in, memwrite_in, regwrite_in, dmem_ack;
  logic [4:0]  rd_in;
  logic        dmem_req, dmem_we, stall, pcsrc, flush, memtoreg_out, regwrite_out;
  logic [31:0] dmem_addr, dmem_wdata, branch_target, readdata_out, alu_result_out;
  logic [4:0]  rd_out;
`ifdef MEM_STAGE_TIMEOUT_EN
  logic        dmem_err;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;

  mem_stage #(
    .XLEN          (32),
    .REG_AW        (5)
`ifdef MEM_STAGE_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(4)
`endif
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .adder_in      (adder_in),
    .zero_in       (zero_in),
    .alu_result_in (alu_result_in),
    .writedata_in  (writedata_in),
    .rd_in         (rd_in),
    .branch_in     (branch_in),
    .memtoreg_in   (memtoreg_in),
    .memwrite_in   (memwrite_in),
    .regwrite_in   (regwrite_in),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .dmem_rdata    (dmem_rdata),
    .dmem_ack      (dmem_ack),
    .stall         (stall),
    .pcsrc         (pcsrc),
    .branch_target (branch_target),
    .flush         (flush),
    .readdata_out  (readdata_out),
    .alu_result_out(alu_result_out),
    .rd_out        (rd_out),
    .memtoreg_out  (memtoreg_out),
    .regwrite_out  (regwrite_out)
`ifdef MEM_STAGE_TIMEOUT_EN
    ,
    .dmem_err      (dmem_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic br, input logic mtr, input logic mw, input logic rw,
                    input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd);
    branch_in     = br;
    memtoreg_in   = mtr;
    memwrite_in   = mw;
    regwrite_in   = rw;
    alu_result_in = alu;
    writedata_in  = wd;
    rd_in         = rd;
  endtask

  task automatic check_wb(input string tag, input logic [31:0] rdat, input logic [31:0] alu,
                          input logic [4:0] rd, input logic mtr, input logic rw);
    check({tag, ".readdata"}, readdata_out, rdat);
    check({tag, ".alu"}, alu_result_out, alu);
    check({tag, ".rd"}, 32'(rd_out), 32'(rd));
    check({tag, ".memtoreg"}, 32'(memtoreg_out), 32'(mtr));
    check({tag, ".regwrite"}, 32'(regwrite_out), 32'(rw));
  endtask

  initial begin
    reset      = 1'b1;
    adder_in   = '0;
    zero_in    = 1'b0;
    dmem_ack   = 1'b0;
    dmem_rdata = '0;
    op(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    step();
    step();
    check_wb("reset", 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    check("reset.state", 32'(dut.state_q), 32'(IDLE));
    reset = 1'b0;

    // Branch resolution is purely combinational.
    op(1'b1, 1'b0, 1'b0, 1'b0, 32'h55, 32'h0, 5'd3);
    zero_in  = 1'b1;
    adder_in = 32'h100;
    #1;
    check("br.pcsrc", 32'(pcsrc), 32'd1);
    check("br.flush", 32'(flush), 32'd1);
    check("br.target", branch_target, 32'h100);
    check("br.stall", 32'(stall), 32'd0);
    check("br.req", 32'(dmem_req), 32'd0);
    zero_in = 1'b0;
    #1;
    check("nbr.pcsrc", 32'(pcsrc), 32'd0);
    check("nbr.flush", 32'(flush), 32'd0);

    // ALU op: one edge to MEM/WB, readdata untouched.
    op(1'b0, 1'b0, 1'b0, 1'b1, 32'h55, 32'h0, 5'd3);
    step();
    check_wb("alu", 32'h0, 32'h55, 5'd3, 1'b0, 1'b1);

    // Zero-wait load.
    op(1'b0, 1'b1, 1'b0, 1'b1, 32'h40, 32'h0, 5'd5);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hDEADBEEF;
    #1;
    check("ld0.stall", 32'(stall), 32'd0);
    check("ld0.req", 32'(dmem_req), 32'd1);
    check("ld0.we", 32'(dmem_we), 32'd0);
    check("ld0.addr", dmem_addr, 32'h40);
    step();
    check_wb("ld0", 32'hDEADBEEF, 32'h40, 5'd5, 1'b1, 1'b1);
    check("ld0.state", 32'(dut.state_q), 32'(IDLE));

    // ALU op with stray ack and changed rdata: readdata holds, no stall.
    op(1'b0, 1'b0, 1'b0, 1'b1, 32'h66, 32'h0, 5'd6);
    dmem_rdata = 32'h11111111;
    #1;
    check("stray.stall", 32'(stall), 32'd0);
    step();
    check_wb("alu2", 32'hDEADBEEF, 32'h66, 5'd6, 1'b0, 1'b1);
    check("stray.state", 32'(dut.state_q), 32'(IDLE));

    // 3-wait store: bubbles hold data fields, request stays stable.
    op(1'b0, 1'b0, 1'b1, 1'b0, 32'h80, 32'h1234, 5'd0);
    dmem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("st.stall%0d", i), 32'(stall), 32'd1);
      check($sformatf("st.we%0d", i), 32'(dmem_we), 32'd1);
      check($sformatf("st.addr%0d", i), dmem_addr, 32'h80);
      check($sformatf("st.wdata%0d", i), dmem_wdata, 32'h1234);
      step();
      check_wb($sformatf("st.bub%0d", i), 32'hDEADBEEF, 32'h66, 5'd6, 1'b0, 1'b0);
      check($sformatf("st.state%0d", i), 32'(dut.state_q), 32'(BUSY));
    end
    dmem_ack = 1'b1;
    #1;
    check("st.release", 32'(stall), 32'd0);
    step();
    check_wb("st.done", 32'hDEADBEEF, 32'h80, 5'd0, 1'b0, 1'b0);
    check("st.state_end", 32'(dut.state_q), 32'(IDLE));

    // Load with one wait, then ALU op right behind it.
    op(1'b0, 1'b1, 1'b0, 1'b1, 32'h44, 32'h0, 5'd8);
    dmem_ack = 1'b0;
    #1;
    check("ld1.stall", 32'(stall), 32'd1);
    step();
    check("ld1.bub_rw", 32'(regwrite_out), 32'd0);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hCAFEF00D;
    #1;
    check("ld1.release", 32'(stall), 32'd0);
    step();
    check_wb("ld1", 32'hCAFEF00D, 32'h44, 5'd8, 1'b1, 1'b1);
    op(1'b0, 1'b0, 1'b0, 1'b1, 32'h9, 32'h0, 5'd7);
    dmem_ack = 1'b0;
    #1;
    check("alu3.stall", 32'(stall), 32'd0);
    step();
    check_wb("alu3", 32'hCAFEF00D, 32'h9, 5'd7, 1'b0, 1'b1);

    // Reset on the 2nd wait cycle abandons the access.
    op(1'b0, 1'b1, 1'b0, 1'b1, 32'h200, 32'h0, 5'd9);
    step();
    check("rst.busy", 32'(dut.state_q), 32'(BUSY));
    reset = 1'b1;
    op(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    #1;
    check_wb("rst", 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    check("rst.state", 32'(dut.state_q), 32'(IDLE));
    check("rst.req", 32'(dmem_req), 32'd0);
    check("rst.stall", 32'(stall), 32'd0);
    step();
    reset = 1'b0;

`ifdef MEM_STAGE_TIMEOUT_EN
    // Timeout: IDLE stall cycle, 4 counted BUSY cycles, abort on the next.
    op(1'b0, 1'b0, 1'b0, 1'b1, 32'h33, 32'h0, 5'd4);
    step();
    check("to.pre_rw", 32'(regwrite_out), 32'd1);
    check("to.err_idle", 32'(dmem_err), 32'd0);
    op(1'b0, 1'b1, 1'b0, 1'b1, 32'h300, 32'h0, 5'd10);
    dmem_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("to.stall%0d", i), 32'(stall), 32'd1);
      check($sformatf("to.err%0d", i), 32'(dmem_err), 32'd0);
      step();
      check($sformatf("to.bub%0d", i), 32'(regwrite_out), 32'd0);
    end
    #1;
    check("to.err", 32'(dmem_err), 32'd1);
    check("to.stall", 32'(stall), 32'd0);
    step();
    check("to.bub_rw", 32'(regwrite_out), 32'd0);
    check("to.bub_mtr", 32'(memtoreg_out), 32'd0);
    check("to.state", 32'(dut.state_q), 32'(IDLE));
    op(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    #1;
    check("to.err_clr", 32'(dmem_err), 32'd0);
    step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
